io_ctrl: RTL

//  Memory-mapped I/O controller on the processor's M-stage data bus (addr/store-data/write-enable).

---
 rtl/io_ctrl_pkg.sv | 50 +++++
 rtl/io_debounce.sv | 45 ++++
 rtl/io_ctrl.sv | 117 +++++++++++
 3 files changed

// File: rtl/io_ctrl_pkg.sv
// Shared definitions for the memory-mapped I/O block: register addresses,
// status-flag layout and the flag update rule used by KCTRL and TCTL.
package io_ctrl_pkg;

  localparam logic [15:0] ADDR_TCNT  = 16'hFFE0;
  localparam logic [15:0] ADDR_TLIM  = 16'hFFE2;
  localparam logic [15:0] ADDR_TCTL  = 16'hFFE4;
  localparam logic [15:0] ADDR_KDATA = 16'hFFF0;
  localparam logic [15:0] ADDR_SDATA = 16'hFFF2;
  localparam logic [15:0] ADDR_KCTRL = 16'hFFF4;
  localparam logic [15:0] ADDR_HEX   = 16'hFFF8;
  localparam logic [15:0] ADDR_LEDR  = 16'hFFFA;
  localparam logic [15:0] ADDR_LEDG  = 16'hFFFC;

  localparam logic [10:0] IO_WINDOW     = 11'h7FF;
  localparam logic [15:0] UNMAPPED_DATA = 16'hDEAD;

  localparam int RDY_BIT = 0;
  localparam int OVR_BIT = 2;

  typedef struct packed {
    logic ovr;
    logic rdy;
  } flags_t;

  // Write-zero-to-clear first, then a same-cycle event sets RDY and flags
  // overrun if RDY was already set before this cycle.
  function automatic flags_t update_flags(input flags_t cur, input logic wr,
                                          input logic keep_rdy, input logic keep_ovr,
                                          input logic ev);
    flags_t nxt;
    nxt = cur;
    if (wr) begin
      nxt.rdy = cur.rdy & keep_rdy;
      nxt.ovr = cur.ovr & keep_ovr;
    end
    if (ev) begin
      nxt.ovr = nxt.ovr | cur.rdy;
      nxt.rdy = 1'b1;
    end
    return nxt;
  endfunction

  function automatic logic [15:0] flags_word(input flags_t f);
    flags_word = '0;
    flags_word[RDY_BIT] = f.rdy;
    flags_word[OVR_BIT] = f.ovr;
  endfunction

endpackage

// File: rtl/io_debounce.sv
// Two-flop synchronizer followed by a tick-based debouncer; a new value is
// accepted only after it has differed from the stable value for DEB_MS ticks.
module io_debounce #(
  parameter int W      = 4,
  parameter int DEB_MS = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         tick,
  input  logic [W-1:0] raw,
  output logic [W-1:0] stable,
  output logic         change
);

  localparam int CW = $clog2(DEB_MS + 1);

  logic [W-1:0]  meta;
  logic [W-1:0]  synced;
  logic [CW-1:0] count;

  // Acceptance happens on the tick that completes the DEB_MS-th count, so the
  // change pulse lines up with the edge that loads the new stable value.
  assign change = tick && (synced != stable) && (count == CW'(DEB_MS - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      meta   <= '0;
      synced <= '0;
      stable <= '0;
      count  <= '0;
    end else begin
      meta   <= raw;
      synced <= meta;
      if (synced == stable) begin
        count <= '0;
      end else if (change) begin
        stable <= synced;
        count  <= '0;
      end else if (tick) begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/io_ctrl.sv
// M-stage memory-mapped I/O controller: display/LED registers, debounced
// KEY/SW inputs with change flags, and a millisecond interval timer.
module io_ctrl
  import io_ctrl_pkg::*;
#(
  parameter int DBITS   = 16,
  parameter int CLK_KHZ = 50000,
  parameter int DEB_MS  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DBITS-1:0] addr,
  input  logic [DBITS-1:0] din,
  input  logic             we,
  output logic             sel,
  output logic [DBITS-1:0] dout,
  input  logic [3:0]       key,
  input  logic [9:0]       sw,
  output logic [15:0]      hex,
  output logic [9:0]       ledr,
  output logic [7:0]       ledg
);

  localparam int PW = (CLK_KHZ > 1) ? $clog2(CLK_KHZ) : 1;

  logic [PW-1:0] presc;
  logic          tick;
  logic          wr, wr_tcnt, wr_tlim, wr_tctl, wr_kctrl;
  logic [15:0]   tcnt, tlim;
  logic          timer_wrap;
  flags_t        kflags, tflags;
  logic [3:0]    key_stable;
  logic          key_change;
  logic [9:0]    sw_stable;

  assign sel      = (addr[15:5] == IO_WINDOW);
  assign wr       = we && sel;
  assign wr_tcnt  = wr && (addr == ADDR_TCNT);
  assign wr_tlim  = wr && (addr == ADDR_TLIM);
  assign wr_tctl  = wr && (addr == ADDR_TCTL);
  assign wr_kctrl = wr && (addr == ADDR_KCTRL);

  assign tick = (presc == PW'(CLK_KHZ - 1));

  // A TCNT write restarts the millisecond phase so the new count gets a full tick.
  always_ff @(posedge clk) begin
    if (reset || wr_tcnt || tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  io_debounce #(.W(4), .DEB_MS(DEB_MS)) u_key_deb (
    .clk    (clk),
    .reset  (reset),
    .tick   (tick),
    .raw    (~key),
    .stable (key_stable),
    .change (key_change)
  );

  io_debounce #(.W(10), .DEB_MS(DEB_MS)) u_sw_deb (
    .clk    (clk),
    .reset  (reset),
    .tick   (tick),
    .raw    (sw),
    .stable (sw_stable),
    .change ()
  );

  assign timer_wrap = tick && !wr_tcnt && (tlim != 16'd0) && (tcnt >= tlim - 16'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      hex    <= '0;
      ledr   <= '0;
      ledg   <= '0;
      tcnt   <= '0;
      tlim   <= '0;
      kflags <= '0;
      tflags <= '0;
    end else begin
      if (wr && (addr == ADDR_HEX))  hex  <= din[15:0];
      if (wr && (addr == ADDR_LEDR)) ledr <= din[9:0];
      if (wr && (addr == ADDR_LEDG)) ledg <= din[7:0];
      if (wr_tlim)                   tlim <= din[15:0];
      if (wr_tcnt) begin
        tcnt <= din[15:0];
      end else if (tick) begin
        tcnt <= timer_wrap ? 16'd0 : tcnt + 16'd1;
      end
      kflags <= update_flags(kflags, wr_kctrl, din[RDY_BIT], din[OVR_BIT], key_change);
      tflags <= update_flags(tflags, wr_tctl, din[RDY_BIT], din[OVR_BIT], timer_wrap);
    end
  end

  // Combinational read path feeding the M-stage load mux.
  always_comb begin
    dout = '0;
    if (sel) begin
      case (addr)
        ADDR_KDATA: dout = {12'd0, key_stable};
        ADDR_SDATA: dout = {6'd0, sw_stable};
        ADDR_KCTRL: dout = flags_word(kflags);
        ADDR_HEX:   dout = hex;
        ADDR_LEDR:  dout = {6'd0, ledr};
        ADDR_LEDG:  dout = {8'd0, ledg};
        ADDR_TCNT:  dout = tcnt;
        ADDR_TLIM:  dout = tlim;
        ADDR_TCTL:  dout = flags_word(tflags);
        default:    dout = UNMAPPED_DATA;
      endcase
    end
  end

endmodule
